// File: rtl/cpu_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the RV32I datapath.
// The master side is the FSM; the slave side is the datapath/RAM.
interface cpu_ctrl_if;
  logic [31:0] instr;
  logic        br_taken;
  logic        dmem_ack;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        rf_we;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  wb_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic [2:0]  state_o;
  logic        halted;
  logic        fault;

  modport master (
    input  instr, br_taken, dmem_ack,
    output pc_we, pc_sel, ir_we, rf_we,
    output alu_src_a, alu_src_b, alu_op,
    output wb_sel, dmem_req, dmem_we,
    output state_o, halted, fault
  );

  modport slave (
    output instr, br_taken, dmem_ack,
    input  pc_we, pc_sel, ir_we, rf_we,
    input  alu_src_a, alu_src_b, alu_op,
    input  wb_sel, dmem_req, dmem_we,
    input  state_o, halted, fault
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Enables are decoded from state, opcode and same-cycle handshakes.
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int RESET_PC_SEL = 0
) (
  input logic       clk,
  input logic       rst,
  cpu_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          halted_q;
  logic          fault_q;

  logic [6:0] opc;
  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_imm;
  logic is_op, is_sys, legal;

  assign opc      = bus.instr[6:0];
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_ld    = opc == 7'b0000011;
  assign is_st    = opc == 7'b0100011;
  assign is_imm   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;
  assign is_sys   = opc == 7'b1110011;
  assign legal    = is_lui | is_auipc | is_jal
                  | is_jalr | is_br | is_ld
                  | is_st | is_imm | is_op
                  | is_sys;

  // PC reset value lives in the datapath; upper IR bits are decoded there.
  logic unused_ok;
  assign unused_ok = (RESET_PC_SEL != 0)
                   ^ (^bus.instr[31:7]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      cnt      <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          if (is_sys) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else if (!legal) begin
            state   <= HALT;
            fault_q <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_ld || is_st) begin
            state <= MEM;
            cnt   <= '0;
          end else if (is_br) begin
            state <= FETCH;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (bus.dmem_ack) begin
            state <= is_st ? FETCH : WB;
          end else if (cnt == LAST) begin
            state   <= HALT;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.pc_we     = 1'b0;
    bus.pc_sel    = 2'd0;
    bus.ir_we     = 1'b0;
    bus.rf_we     = 1'b0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 2'd0;
    bus.alu_op    = 2'd0;
    bus.wb_sel    = 2'd0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.state_o   = rst ? 3'd0 : state;
    bus.halted    = halted_q & ~rst;
    bus.fault     = fault_q & ~rst;
    if (!rst) begin
      unique case (state)
        FETCH: bus.ir_we = 1'b1;
        EXEC: begin
          unique case (1'b1)
            is_op: bus.alu_op = 2'd2;
            is_imm: begin
              bus.alu_src_b = 2'd1;
              bus.alu_op    = 2'd2;
            end
            is_lui: begin
              bus.alu_src_a = 2'd2;
              bus.alu_src_b = 2'd1;
            end
            is_auipc, is_jal: begin
              bus.alu_src_a = 2'd1;
              bus.alu_src_b = 2'd1;
            end
            is_jalr, is_ld, is_st:
              bus.alu_src_b = 2'd1;
            is_br: begin
              bus.alu_op = 2'd3;
              bus.pc_we  = 1'b1;
              bus.pc_sel = bus.br_taken ? 2'd2 : 2'd0;
            end
            default: ;
          endcase
        end
        MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we  = is_st;
          bus.pc_we    = bus.dmem_ack & is_st;
        end
        WB: begin
          bus.rf_we = 1'b1;
          bus.pc_we = 1'b1;
          if (is_ld) begin
            bus.wb_sel = 2'd1;
          end else if (is_jal || is_jalr) begin
            bus.wb_sel = 2'd2;
            bus.pc_sel = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: per-cycle stimulus and
// expected control vectors are queued, then replayed and compared.
module tb_cpu_ctrl_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_ctrl_fsm #(.MEM_TIMEOUT(16), .RESET_PC_SEL(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic [31:0] instr;
    logic        ack;
    logic        bt;
    logic [19:0] exp;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // {pc_we,pc_sel,ir_we,rf_we,a,b,op,wb,req,we,state,halted,fault}
  function automatic logic [19:0] ev(
    int st, int pcwe, int pcsel, int irwe, int rfwe,
    int a, int b, int op, int wb, int req, int we,
    int h, int f);
    return {pcwe[0], pcsel[1:0], irwe[0], rfwe[0],
            a[1:0], b[1:0], op[1:0], wb[1:0],
            req[0], we[0], st[2:0], h[0], f[0]};
  endfunction

  function automatic logic [19:0] got_vec();
    return {bus.pc_we, bus.pc_sel, bus.ir_we,
            bus.rf_we, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.wb_sel, bus.dmem_req,
            bus.dmem_we, bus.state_o, bus.halted,
            bus.fault};
  endfunction

  task automatic push(input string tag, input logic r,
                      input logic [31:0] ins, input logic ack,
                      input logic bt, input logic [19:0] e);
    ent_t x;
    x.tag = tag; x.rst = r; x.instr = ins;
    x.ack = ack; x.bt = bt; x.exp = e;
    q.push_back(x);
  endtask

  task automatic push_fd(input string tag, input logic [31:0] ins);
    push({tag, "_fetch"}, 0, ins, 0, 0,
         ev(0, 0,0,1,0, 0,0,0,0, 0,0, 0,0));
    push({tag, "_decode"}, 0, ins, 0, 0,
         ev(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0));
  endtask

  task automatic push_rst(input string tag);
    push({tag, "_rst0"}, 1, 32'h0, 1, 1, 20'h0);
    push({tag, "_rst1"}, 1, 32'h0, 0, 0, 20'h0);
  endtask

  task automatic drain();
    int budget = 1000;
    while (q.size() > 0 && budget > 0) begin
      ent_t x;
      x = q.pop_front();
      rst = x.rst;
      bus.instr = x.instr;
      bus.dmem_ack = x.ack;
      bus.br_taken = x.bt;
      #1;
      check(x.tag, 32'(got_vec()), 32'(x.exp));
      @(negedge clk);
      budget--;
    end
    check("drain_budget", 32'(q.size()), 32'd0);
  endtask

  localparam logic [31:0] ADDI = 32'h00a00093;
  localparam logic [31:0] LW   = 32'h00002203;
  localparam logic [31:0] SW   = 32'h00302023;
  localparam logic [31:0] BEQ  = 32'h00000463;
  localparam logic [31:0] JAL  = 32'h008000ef;
  localparam logic [31:0] LUI  = 32'h000012b7;
  localparam logic [31:0] AUIP = 32'h00000117;
  localparam logic [31:0] ECAL = 32'h00000073;

  initial begin
    rst = 1'b1;
    bus.instr = '0;
    bus.dmem_ack = 1'b0;
    bus.br_taken = 1'b0;
    @(negedge clk);
    push_rst("reset");

    push_fd("addi", ADDI);
    push("addi_exec", 0, ADDI, 0, 0,
         ev(2, 0,0,0,0, 0,1,2,0, 0,0, 0,0));
    push("addi_wb", 0, ADDI, 0, 0,
         ev(4, 1,0,0,1, 0,0,0,0, 0,0, 0,0));

    push_fd("lw", LW);
    push("lw_exec", 0, LW, 0, 0,
         ev(2, 0,0,0,0, 0,1,0,0, 0,0, 0,0));
    for (int i = 0; i < 3; i++)
      push("lw_wait", 0, LW, 0, 0,
           ev(3, 0,0,0,0, 0,0,0,0, 1,0, 0,0));
    push("lw_ack", 0, LW, 1, 0,
         ev(3, 0,0,0,0, 0,0,0,0, 1,0, 0,0));
    push("lw_wb", 0, LW, 0, 0,
         ev(4, 1,0,0,1, 0,0,0,1, 0,0, 0,0));

    push_fd("sw", SW);
    push("sw_exec", 0, SW, 0, 0,
         ev(2, 0,0,0,0, 0,1,0,0, 0,0, 0,0));
    push("sw_ack", 0, SW, 1, 0,
         ev(3, 1,0,0,0, 0,0,0,0, 1,1, 0,0));

    push_fd("beq_t", BEQ);
    push("beq_t_exec", 0, BEQ, 0, 1,
         ev(2, 1,2,0,0, 0,0,3,0, 0,0, 0,0));
    push_fd("beq_n", BEQ);
    push("beq_n_exec", 0, BEQ, 0, 0,
         ev(2, 1,0,0,0, 0,0,3,0, 0,0, 0,0));

    push_fd("jal", JAL);
    push("jal_exec", 0, JAL, 0, 0,
         ev(2, 0,0,0,0, 1,1,0,0, 0,0, 0,0));
    push("jal_wb", 0, JAL, 0, 0,
         ev(4, 1,1,0,1, 0,0,0,2, 0,0, 0,0));

    push_fd("lui", LUI);
    push("lui_exec", 0, LUI, 0, 0,
         ev(2, 0,0,0,0, 2,1,0,0, 0,0, 0,0));
    push("lui_wb", 0, LUI, 0, 0,
         ev(4, 1,0,0,1, 0,0,0,0, 0,0, 0,0));

    push("auipc_fetch", 0, AUIP, 1, 1,
         ev(0, 0,0,1,0, 0,0,0,0, 0,0, 0,0));
    push("auipc_exec_pre", 0, AUIP, 1, 1,
         ev(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0));
    push("auipc_exec", 0, AUIP, 1, 1,
         ev(2, 0,0,0,0, 1,1,0,0, 0,0, 0,0));
    push("auipc_wb", 0, AUIP, 1, 1,
         ev(4, 1,0,0,1, 0,0,0,0, 0,0, 0,0));

    push_fd("lw_rst", LW);
    push("lw_rst_exec", 0, LW, 0, 0,
         ev(2, 0,0,0,0, 0,1,0,0, 0,0, 0,0));
    push("lw_rst_mem", 0, LW, 0, 0,
         ev(3, 0,0,0,0, 0,0,0,0, 1,0, 0,0));
    push("lw_rst_pulse", 1, LW, 0, 0, 20'h0);
    push("lw_rst_after", 0, LW, 1, 0,
         ev(0, 0,0,1,0, 0,0,0,0, 0,0, 0,0));
    push("lw_rst_dec", 0, LW, 0, 0,
         ev(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0));
    push("lw_rst_exec2", 0, LW, 0, 0,
         ev(2, 0,0,0,0, 0,1,0,0, 0,0, 0,0));
    push("lw_rst_mem2", 0, LW, 1, 0,
         ev(3, 0,0,0,0, 0,0,0,0, 1,0, 0,0));
    push("lw_rst_wb", 0, LW, 0, 0,
         ev(4, 1,0,0,1, 0,0,0,1, 0,0, 0,0));

    push_fd("ill", 32'h0);
    for (int i = 0; i < 2; i++)
      push("ill_halt", 0, 32'h0, 1, 1,
           ev(5, 0,0,0,0, 0,0,0,0, 0,0, 0,1));
    push_rst("ill");

    push_fd("ecall", ECAL);
    for (int i = 0; i < 2; i++)
      push("ecall_halt", 0, ECAL, 1, 0,
           ev(5, 0,0,0,0, 0,0,0,0, 0,0, 1,0));
    push_rst("ecall");

    push_fd("tmo", LW);
    push("tmo_exec", 0, LW, 0, 0,
         ev(2, 0,0,0,0, 0,1,0,0, 0,0, 0,0));
    for (int i = 0; i < 16; i++)
      push("tmo_wait", 0, LW, 0, 0,
           ev(3, 0,0,0,0, 0,0,0,0, 1,0, 0,0));
    for (int i = 0; i < 2; i++)
      push("tmo_halt", 0, LW, 1, 0,
           ev(5, 0,0,0,0, 0,0,0,0, 0,0, 0,1));
    push_rst("tmo");
    push_fd("post", ADDI);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
